// File: rtl/md_unit_if.sv
// Decoder-to-multiply/divide bundle: the operation request and the HI/LO read path.
`default_nettype none

interface md_unit_if;
  logic [2:0]  md_op;
  logic        start;
  logic        flush;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mdm_sel;
  logic        busy;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_op, start, flush, src_a, src_b, mdm_sel,
    input  busy, rd_data, hi, lo
  );

  modport slave (
    input  md_op, start, flush, src_a, src_b, mdm_sel,
    output busy, rd_data, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/md_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine that owns HI/LO and services MTHI/MTLO writes.
`default_nettype none

module md_unit #(
  parameter int MUL_CYCLES = 5
) (
  input  logic       clk,
  input  logic       resetn,
  md_unit_if.slave   md
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LAST = 6'd32;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        sgn_q, sgn_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        dz_q, dz_d;

  logic        accept;
  logic        mt_wr;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [63:0] mul_a, mul_b, prod;
  logic [32:0] rem_shift;
  logic [31:0] rem_sub;
  logic        rem_ge;
  logic [31:0] quo_fix, rem_fix;

  assign accept = (state_q == S_IDLE) && md.start && !md.flush && !md.md_op[2];
  assign mt_wr  = (state_q == S_IDLE) && !md.flush && (md.md_op[2:1] == 2'b10);

  assign a_neg = !md.md_op[0] && md.src_a[31];
  assign b_neg = !md.md_op[0] && md.src_b[31];
  assign a_mag = a_neg ? (32'd0 - md.src_a) : md.src_a;
  assign b_mag = b_neg ? (32'd0 - md.src_b) : md.src_b;

  // Sign-extending to 64 bits makes the low 64 bits of one unsigned multiply
  // correct for both the signed and unsigned product.
  assign mul_a = {{32{sgn_q & op_a_q[31]}}, op_a_q};
  assign mul_b = {{32{sgn_q & op_b_q[31]}}, op_b_q};
  assign prod  = mul_a * mul_b;

  // One restoring step: the difference fits in 32 bits whenever it is kept.
  assign rem_shift = {rem_q, quo_q[31]};
  assign rem_ge    = rem_shift >= {1'b0, dvs_q};
  assign rem_sub   = rem_shift[31:0] - dvs_q;

  assign quo_fix = q_neg_q ? (32'd0 - quo_q) : quo_q;
  assign rem_fix = r_neg_q ? (32'd0 - rem_q) : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sgn_d   = sgn_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_a_d = md.src_a;
          op_b_d = md.src_b;
          sgn_d  = !md.md_op[0];
          cnt_d  = 6'd0;
          if (md.md_op[1]) begin
            state_d = S_DIV;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            rem_d   = 32'd0;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
            dz_d    = (md.src_b == 32'd0);
          end else begin
            state_d = S_MUL;
          end
        end else if (mt_wr) begin
          if (md.md_op[0]) lo_d = md.src_a;
          else             hi_d = md.src_a;
        end
      end

      S_MUL: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == MUL_LAST) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          cnt_d   = 6'd0;
          state_d = S_IDLE;
        end
      end

      S_DIV: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == DIV_LAST) begin
          // Zero divisor returns all-ones quotient and the raw dividend regardless of sign.
          lo_d    = dz_q ? 32'hFFFF_FFFF : quo_fix;
          hi_d    = dz_q ? op_a_q : rem_fix;
          cnt_d   = 6'd0;
          state_d = S_IDLE;
        end else begin
          quo_d = {quo_q[30:0], rem_ge};
          rem_d = rem_ge ? rem_sub : rem_shift[31:0];
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      op_a_q  <= 32'd0;
      op_b_q  <= 32'd0;
      sgn_q   <= 1'b0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      dvs_q   <= 32'd0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sgn_q   <= sgn_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
    end
  end

  assign md.busy    = (state_q != S_IDLE);
  assign md.hi      = hi_q;
  assign md.lo      = lo_q;
  assign md.rd_data = md.mdm_sel ? lo_q : hi_q;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: directed ops queue expected HI/LO and latency; a monitor checks on completion.
`timescale 1ns/1ps
`default_nettype none

module tb_md_unit;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  md_unit_if u_if();

  md_unit #(.MUL_CYCLES(5)) dut (
    .clk    (clk),
    .resetn (resetn),
    .md     (u_if.slave)
  );

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   bcnt  = 0;
  bit   prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles and scores each completion against the queue head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        prev_busy = 1'b0;
        bcnt      = 0;
      end else if (u_if.busy) begin
        bcnt++;
        prev_busy = 1'b1;
      end else if (prev_busy) begin
        prev_busy = 1'b0;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_completion: got busy cycles %0d, want no operation", bcnt);
        end else begin
          e = sb.pop_front();
          check({e.name, "_latency"}, 32'(bcnt), 32'(e.lat));
          check({e.name, "_hi"}, u_if.hi, e.hi);
          check({e.name, "_lo"}, u_if.lo, e.lo);
        end
        bcnt = 0;
      end
    end
  end

  task automatic push_exp(input string name, input logic [31:0] eh, input logic [31:0] el,
                          input int lat);
    exp_t e;
    e.name = name;
    e.hi   = eh;
    e.lo   = el;
    e.lat  = lat;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (u_if.busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (u_if.busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got busy after %0d cycles, want idle", name, k);
    end
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    u_if.md_op = op;
    u_if.src_a = a;
    u_if.src_b = b;
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
  endtask

  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input int lat);
    push_exp(name, eh, el, lat);
    launch(op, a, b);
    wait_idle(name);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    resetn       = 1'b0;
    u_if.md_op   = 3'b000;
    u_if.start   = 1'b0;
    u_if.flush   = 1'b0;
    u_if.src_a   = 32'd0;
    u_if.src_b   = 32'd0;
    u_if.mdm_sel = 1'b0;

    #2;
    check("reset_hi", u_if.hi, 32'd0);
    check("reset_lo", u_if.lo, 32'd0);
    check("reset_busy", {31'd0, u_if.busy}, 32'd0);
    check("reset_rd_data", u_if.rd_data, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_hi", u_if.hi, 32'd0);
    check("idle_lo", u_if.lo, 32'd0);
    check("idle_busy", {31'd0, u_if.busy}, 32'd0);

    do_op("mult_neg1x2",  3'b000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    u_if.mdm_sel = 1'b1;
    #1 check("rd_data_lo", u_if.rd_data, 32'hFFFF_FFFE);
    u_if.mdm_sel = 1'b0;
    #1 check("rd_data_hi", u_if.rd_data, 32'hFFFF_FFFF);
    do_op("multu_maxx2",  3'b001, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5);
    do_op("mult_minsq",   3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 5);
    do_op("div_m7_2",     3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    do_op("div_7_m2",     3'b010, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
    do_op("divu_7_2",     3'b011, 32'd7, 32'd2, 32'd1, 32'd3, 33);
    do_op("divu_max_16",  3'b011, 32'hFFFF_FFFF, 32'd16, 32'hF, 32'h0FFF_FFFF, 33);
    do_op("divu_by0",     3'b011, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 33);
    do_op("div_neg_by0",  3'b010, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 33);
    do_op("div_ovf",      3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
    do_op("mult_seed",    3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 5);

    // MTLO / MTHI need no start: md_op alone requests the write in IDLE.
    @(negedge clk);
    u_if.md_op = 3'b101;
    u_if.src_a = 32'h0000_ABCD;
    @(negedge clk);
    u_if.md_op = 3'b000;
    check("mtlo_lo", u_if.lo, 32'h0000_ABCD);
    check("mtlo_hi_kept", u_if.hi, 32'h4000_0000);
    u_if.md_op = 3'b100;
    u_if.src_a = 32'h0000_5555;
    @(negedge clk);
    u_if.md_op = 3'b000;
    check("mthi_hi", u_if.hi, 32'h0000_5555);

    u_if.md_op = 3'b100;
    u_if.src_a = 32'h0000_DEAD;
    u_if.flush = 1'b1;
    @(negedge clk);
    u_if.md_op = 3'b000;
    u_if.flush = 1'b0;
    check("mthi_flush_hi", u_if.hi, 32'h0000_5555);

    u_if.start = 1'b1;
    u_if.flush = 1'b1;
    u_if.src_a = 32'd3;
    u_if.src_b = 32'd4;
    @(negedge clk);
    u_if.start = 1'b0;
    u_if.flush = 1'b0;
    check("start_flush_busy", {31'd0, u_if.busy}, 32'd0);
    @(negedge clk);
    check("start_flush_busy2", {31'd0, u_if.busy}, 32'd0);
    check("start_flush_lo", u_if.lo, 32'h0000_ABCD);

    // A DIV must ignore a new start and MT writes while it runs, and keep HI/LO readable.
    push_exp("div_busy_ign", 32'd2, 32'd14, 33);
    launch(3'b010, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    check("busy_read_hi", u_if.hi, 32'h0000_5555);
    u_if.mdm_sel = 1'b1;
    #1 check("busy_read_lo", u_if.rd_data, 32'h0000_ABCD);
    u_if.mdm_sel = 1'b0;
    u_if.md_op = 3'b001;
    u_if.src_a = 32'd9;
    u_if.src_b = 32'd9;
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    u_if.md_op = 3'b101;
    u_if.src_a = 32'h0000_FFFF;
    @(negedge clk);
    u_if.md_op = 3'b100;
    @(negedge clk);
    u_if.md_op = 3'b010;
    wait_idle("div_busy_ign");

    launch(3'b011, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    check("mid_div_busy", {31'd0, u_if.busy}, 32'd1);
    resetn = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, u_if.busy}, 32'd0);
    check("async_rst_hi", u_if.hi, 32'd0);
    check("async_rst_lo", u_if.lo, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    do_op("mult_after_rst", 3'b000, 32'd3, 32'd4, 32'd0, 32'd12, 5);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
